// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, exception flags, post-processor stage record.
package fpu_pkg;

  typedef enum logic [2:0] {
    RmRne = 3'd0,
    RmRtz = 3'd1,
    RmRdn = 3'd2,
    RmRup = 3'd3,
    RmRmm = 3'd4
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Width-independent part of the normalise-to-round stage record.
  typedef struct packed {
    logic sign;
    rm_e  rm;
    logic nan;
    logic inf;
    logic zero;
    logic nv;
    logic dz;
    logic tiny;
    logic sticky;
  } s1_ctrl_t;

  // Quiet NaN with a clear sign and only the fraction MSB set.
  function automatic logic [63:0] canonical_nan(input int unsigned ew, input int unsigned fw);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << ew) - 64'd1;
    return (exp_ones << fw) | (64'd1 << (fw - 1));
  endfunction

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] rm);
    return (rm > 3'd4) ? RmRne : rm_e'(rm);
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounding increment decision from the bits just below the result LSB.
module fp_round
  import fpu_pkg::*;
(
  input  logic sign,
  input  rm_e  rm,
  input  logic lsb,
  input  logic guard,
  input  logic round,
  input  logic sticky,
  output logic inc,
  output logic inexact
);

  // Per-mode increment; any discarded bit makes the result inexact.
  always_comb begin
    inexact = guard | round | sticky;
    inc     = 1'b0;
    case (rm)
      RmRne:   inc = guard & (round | sticky | lsb);
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = sign & inexact;
      RmRup:   inc = ~sign & inexact;
      RmRmm:   inc = guard;
      default: inc = guard & (round | sticky | lsb);
    endcase
  end

endmodule

// File: rtl/fppost.sv
// FPU back end: normalise (stage 1), round and pack (stage 2), valid/ready pipeline.
module fppost
  import fpu_pkg::*;
#(
  parameter int unsigned FW = 23,
  parameter int unsigned EW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sign_i,
  input  logic [EW+1:0]    exp_i,
  input  logic [FW+3:0]    sig_i,
  input  logic             sticky_i,
  input  logic [2:0]       rm_i,
  input  logic             nan_i,
  input  logic             inf_i,
  input  logic             zero_i,
  input  logic             nv_i,
  input  logic             dz_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [EW+FW:0]   result_o,
  output logic [4:0]       fflags_o
);

  localparam int unsigned MW = FW + 3;  // {hidden, fraction, guard, round}
  localparam int unsigned XW = EW + 3;  // room for exp_i plus carry increments
  localparam logic [XW-1:0] ExpOvf = XW'((1 << EW) - 1);
  localparam logic [EW+FW:0] QNan = (EW+FW+1)'(canonical_nan(EW, FW));

  logic advance;
  assign advance = ~valid_o | ready_i;
  assign ready_o = advance;

  // ---------------- stage 1: normalise ----------------
  logic [MW-1:0] n1_sig, n1_mask;
  logic [XW-1:0] n1_exp, n1_shamt_raw, n1_shamt;
  logic          n1_sticky, n1_tiny;
  s1_ctrl_t      s1_ctrl_d;

  // Fold a carry back into the hidden bit, then denormalise non-positive exponents.
  always_comb begin
    n1_sig       = sig_i[FW+3] ? sig_i[FW+3:1] : sig_i[FW+2:0];
    n1_sticky    = sticky_i | (sig_i[FW+3] & sig_i[0]);
    n1_exp       = {exp_i[EW+1], exp_i} + XW'(sig_i[FW+3]);
    n1_tiny      = 1'b0;
    n1_shamt_raw = '0;
    n1_shamt     = '0;
    n1_mask      = '0;
    if (n1_exp[XW-1] || n1_exp == '0) begin
      n1_tiny      = 1'b1;
      n1_shamt_raw = XW'(1) - n1_exp;
      // Shifting by the full width drops everything into sticky.
      n1_shamt     = (n1_shamt_raw > XW'(MW)) ? XW'(MW) : n1_shamt_raw;
      n1_mask      = ~({MW{1'b1}} << n1_shamt);
      n1_sticky    = n1_sticky | (|(n1_sig & n1_mask));
      n1_sig       = n1_sig >> n1_shamt;
      n1_exp       = '0;
    end
  end

  // Collect the control fields carried into the round stage.
  always_comb begin
    s1_ctrl_d        = '0;
    s1_ctrl_d.sign   = sign_i;
    s1_ctrl_d.rm     = decode_rm(rm_i);
    s1_ctrl_d.nan    = nan_i;
    s1_ctrl_d.inf    = inf_i;
    s1_ctrl_d.zero   = zero_i;
    s1_ctrl_d.nv     = nv_i;
    s1_ctrl_d.dz     = dz_i;
    s1_ctrl_d.tiny   = n1_tiny;
    s1_ctrl_d.sticky = n1_sticky;
  end

  logic          s1_valid_q;
  logic [MW-1:0] s1_sig_q;
  logic [XW-1:0] s1_exp_q;
  s1_ctrl_t      s1_ctrl_q;

  // Stage-1 register; holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sig_q   <= '0;
      s1_exp_q   <= '0;
      s1_ctrl_q  <= '0;
    end else if (advance) begin
      s1_valid_q <= valid_i;
      s1_sig_q   <= n1_sig;
      s1_exp_q   <= n1_exp;
      s1_ctrl_q  <= s1_ctrl_d;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic r_inc, r_inexact;

  fp_round u_round (
    .sign    (s1_ctrl_q.sign),
    .rm      (s1_ctrl_q.rm),
    .lsb     (s1_sig_q[2]),
    .guard   (s1_sig_q[1]),
    .round   (s1_sig_q[0]),
    .sticky  (s1_ctrl_q.sticky),
    .inc     (r_inc),
    .inexact (r_inexact)
  );

  logic [FW+1:0]  r_man;
  logic [XW-1:0]  r_exp;
  logic [FW-1:0]  r_frac;
  logic           r_ovf, r_max_fin;
  logic [EW+FW:0] r_result;
  fflags_t        r_flags;

  // Apply the increment, renormalise, then pick special / overflow / normal packing.
  always_comb begin
    r_man  = {1'b0, s1_sig_q[MW-1:2]} + (FW+2)'(r_inc);
    r_exp  = s1_exp_q;
    r_frac = r_man[FW-1:0];
    if (r_man[FW+1]) begin
      r_exp  = s1_exp_q + XW'(1);
      r_frac = r_man[FW:1];
    end else if (s1_exp_q == '0 && r_man[FW]) begin
      // Subnormal rounded up into the normal range.
      r_exp = XW'(1);
    end
    r_ovf     = r_exp >= ExpOvf;
    r_max_fin = (s1_ctrl_q.rm == RmRtz) ||
                (s1_ctrl_q.rm == RmRdn && !s1_ctrl_q.sign) ||
                (s1_ctrl_q.rm == RmRup && s1_ctrl_q.sign);
    r_flags    = '0;
    r_flags.nv = s1_ctrl_q.nv;
    r_flags.dz = s1_ctrl_q.dz;
    if (s1_ctrl_q.nan) begin
      r_result = QNan;
    end else if (s1_ctrl_q.inf) begin
      r_result = {s1_ctrl_q.sign, {EW{1'b1}}, {FW{1'b0}}};
    end else if (s1_ctrl_q.zero || (s1_sig_q == '0 && !s1_ctrl_q.sticky)) begin
      r_result = {s1_ctrl_q.sign, {(EW+FW){1'b0}}};
    end else if (r_ovf) begin
      r_result   = r_max_fin ? {s1_ctrl_q.sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}}
                             : {s1_ctrl_q.sign, {EW{1'b1}}, {FW{1'b0}}};
      r_flags.of = 1'b1;
      r_flags.nx = 1'b1;
    end else begin
      r_result   = {s1_ctrl_q.sign, r_exp[EW-1:0], r_frac};
      r_flags.nx = r_inexact;
      r_flags.uf = s1_ctrl_q.tiny & r_inexact;
    end
  end

  // Output register; stable while valid_o is held against a low ready_i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else if (advance) begin
      valid_o  <= s1_valid_q;
      result_o <= r_result;
      fflags_o <= r_flags;
    end
  end

endmodule

// File: tb/tb_fppost.sv
// Self-checking bench for fppost (FW=23, EW=8) with a value-level rounding model.
module tb_fppost;

  localparam int FW = 23;
  localparam int EW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        sign_i = 1'b0;
  logic [9:0]  exp_i = '0;
  logic [26:0] sig_i = '0;
  logic        sticky_i = 1'b0;
  logic [2:0]  rm_i = '0;
  logic        nan_i = 1'b0, inf_i = 1'b0, zero_i = 1'b0, nv_i = 1'b0, dz_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  bit   accepted = 1'b0;
  bit   dir_use = 1'b0;
  exp_t dir_exp;
  int   n_out = 0;
  bit   held_v = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_fl;

  fppost #(.FW(FW), .EW(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .sig_i    (sig_i),
    .sticky_i (sticky_i),
    .rm_i     (rm_i),
    .nan_i    (nan_i),
    .inf_i    (inf_i),
    .zero_i   (zero_i),
    .nv_i     (nv_i),
    .dz_i     (dz_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .fflags_o (fflags_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1);
  end

  // Value-level model: drop k low bits of the integer significand and round the quotient.
  function automatic exp_t ref_model(input logic s, input logic [9:0] e_raw,
                                     input logic [26:0] sig, input logic st,
                                     input logic [2:0] rm, input logic nan, input logic inf,
                                     input logic zero, input logic nv, input logic dz);
    exp_t   r;
    longint n, qv, rem, half;
    int     e, en, k, mode;
    bit     tiny, nx, up, maxfin;
    r.fl = {nv, dz, 3'b000};
    r.res = '0;
    if (nan) begin r.res = 32'h7FC00000; return r; end
    if (inf) begin r.res = {s, 8'hFF, 23'h0}; return r; end
    if (zero) begin r.res = {s, 31'h0}; return r; end
    mode = (rm > 3'd4) ? 0 : int'(rm);
    n    = longint'(sig);
    e    = int'($signed(e_raw));
    en   = e + int'(sig[26]);
    tiny = (en <= 0);
    k    = 2 + int'(sig[26]) + (tiny ? 1 - en : 0);
    if (k > 30) k = 30;
    qv   = n >> k;
    rem  = n & ((longint'(1) << k) - 1);
    half = longint'(1) << (k - 1);
    nx   = (rem != 0) || st;
    case (mode)
      0:       up = (rem > half) || (rem == half && (st || (qv & 1) != 0));
      1:       up = 1'b0;
      2:       up = s && nx;
      3:       up = !s && nx;
      default: up = (rem >= half);
    endcase
    qv = qv + longint'(up);
    if (tiny) begin
      r.res = {s, (qv >= (longint'(1) << FW)) ? 8'd1 : 8'd0, 23'(qv)};
      r.fl[1] = nx;
      r.fl[0] = nx;
      return r;
    end
    if (qv >= (longint'(1) << (FW + 1))) begin
      qv = qv >> 1;
      en = en + 1;
    end
    if (en >= 255) begin
      maxfin = (mode == 1) || (mode == 2 && !s) || (mode == 3 && s);
      r.res  = maxfin ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
      r.fl[2] = 1'b1;
      r.fl[0] = 1'b1;
    end else begin
      r.res   = {s, 8'(en), 23'(qv)};
      r.fl[0] = nx;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic set_in(input logic s, input int e, input logic [26:0] sg, input logic st,
                        input logic [2:0] rm, input logic [4:0] sp);
    sign_i   = s;
    exp_i    = 10'(e);
    sig_i    = sg;
    sticky_i = st;
    rm_i     = rm;
    {nan_i, inf_i, zero_i, nv_i, dz_i} = sp;
  endtask

  task automatic rand_in();
    int          e;
    logic [26:0] s;
    logic [4:0]  sp;
    logic        st;
    s  = 27'($urandom);
    st = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       e = int'($urandom_range(0, 40)) - 35;
      1:       e = int'($urandom_range(1, 253));
      2:       e = int'($urandom_range(245, 300));
      default: e = int'($urandom_range(120, 135));
    endcase
    if ($urandom_range(0, 3) == 0) begin
      s[13:0] = '0;
      st = 1'b0;
    end
    if (e > 0 && !s[26]) s[25] = 1'b1;
    sp = '0;
    case ($urandom_range(0, 15))
      0:       sp[4] = 1'b1;
      1:       sp[3] = 1'b1;
      2:       sp[2] = 1'b1;
      default: sp = sp;
    endcase
    sp[1] = ($urandom_range(0, 7) == 0);
    sp[0] = ($urandom_range(0, 7) == 0);
    set_in(1'($urandom_range(0, 1)), e, s, st, 3'($urandom_range(0, 7)), sp);
  endtask

  // One clock: inputs are already driven; judge handshakes just before the posedge.
  task automatic cycle();
    exp_t x;
    #1;
    accepted = 1'b0;
    if (rst_n) begin
      if (held_v) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_result", 64'(result_o), 64'(held_res));
        chk("hold_flags", 64'(fflags_o), 64'(held_fl));
      end
      if (valid_o && !ready_i) chk("stall_ready_o", 64'(ready_o), 64'd0);
      if (valid_o && ready_i) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_output observed=%h expected=none", result_o);
        end else begin
          x = q.pop_front();
          chk("result", 64'(result_o), 64'(x.res));
          chk("fflags", 64'(fflags_o), 64'(x.fl));
        end
      end
      if (valid_i && ready_o) begin
        accepted = 1'b1;
        q.push_back(dir_use ? dir_exp :
                    ref_model(sign_i, exp_i, sig_i, sticky_i, rm_i, nan_i, inf_i, zero_i,
                              nv_i, dz_i));
      end
    end
    held_v   = rst_n && valid_o && !ready_i;
    held_res = result_o;
    held_fl  = fflags_o;
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [31:0] res, input logic [4:0] fl);
    bit got;
    got      = 1'b0;
    dir_use  = 1'b1;
    dir_exp  = '{res: res, fl: fl};
    valid_i  = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      cycle();
      got = accepted;
    end
    valid_i = 1'b0;
    dir_use = 1'b0;
    chk("send_accepted", 64'(got), 64'd1);
  endtask

  task automatic drain(input int budget);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int idx, stall, n_before;
    bit seen;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_result", 64'(result_o), 64'd0);
    chk("reset_fflags", 64'(fflags_o), 64'd0);
    chk("reset_ready_o", 64'(ready_o), 64'd1);
    rst_n = 1'b1;

    // Directed vectors, streamed back to back
    set_in(0, 127, {2'b01, 23'h0, 2'b00}, 0, 3'd0, 5'b0);
    send_dir(32'h3F800000, 5'b00000);
    set_in(0, 127, {2'b01, 23'h7FFFFF, 2'b10}, 0, 3'd0, 5'b0);
    send_dir(32'h40000000, 5'b00001);
    set_in(0, 127, {2'b01, 23'h7FFFFF, 2'b10}, 0, 3'd1, 5'b0);
    send_dir(32'h3FFFFFFF, 5'b00001);
    set_in(0, 254, {2'b10, 23'h0, 2'b00}, 0, 3'd0, 5'b0);
    send_dir(32'h7F800000, 5'b00101);
    set_in(0, 254, {2'b10, 23'h0, 2'b00}, 0, 3'd1, 5'b0);
    send_dir(32'h7F7FFFFF, 5'b00101);
    set_in(1, 254, {2'b10, 23'h0, 2'b00}, 0, 3'd3, 5'b0);
    send_dir(32'hFF7FFFFF, 5'b00101);
    set_in(0, 0, {2'b01, 23'h0, 2'b00}, 0, 3'd0, 5'b0);
    send_dir(32'h00400000, 5'b00000);
    set_in(0, 0, {2'b01, 23'h0, 2'b01}, 0, 3'd0, 5'b0);
    send_dir(32'h00400000, 5'b00011);
    set_in(0, 5, {2'b01, 23'h0, 2'b00}, 0, 3'd0, 5'b10010);
    send_dir(32'h7FC00000, 5'b10000);
    set_in(1, 5, {2'b01, 23'h0, 2'b00}, 0, 3'd0, 5'b01000);
    send_dir(32'hFF800000, 5'b00000);
    set_in(1, 0, 27'h0, 0, 3'd0, 5'b00000);
    send_dir(32'h80000000, 5'b00000);
    drain(20);

    // A, B, C back to back with a 3-cycle output stall once A appears
    n_before = n_out;
    idx   = 0;
    stall = 3;
    seen  = 1'b0;
    rand_in();
    for (int c = 0; c < 40; c++) begin
      if (valid_o) seen = 1'b1;
      ready_i = !(seen && stall > 0);
      if (seen && stall > 0) stall--;
      valid_i = (idx < 3);
      cycle();
      if (accepted) begin
        idx++;
        if (idx < 3) rand_in();
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("abc_sent", 64'(idx), 64'd3);
    chk("abc_delivered", 64'(n_out - n_before), 64'd3);
    chk("abc_queue_empty", 64'(q.size()), 64'd0);

    // Randomised traffic with random back-pressure
    for (int t = 0; t < 600; t++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      valid_i = ($urandom_range(0, 3) != 0);
      rand_in();
      cycle();
    end
    drain(50);

    // Reset mid-stream discards in-flight data
    ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      valid_i = 1'b1;
      rand_in();
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    chk("midreset_valid_o", 64'(valid_o), 64'd0);
    chk("midreset_result", 64'(result_o), 64'd0);
    chk("midreset_fflags", 64'(fflags_o), 64'd0);
    q.delete();
    rst_n   = 1'b1;
    valid_i = 1'b0;
    n_before = n_out;
    for (int t = 0; t < 5; t++) cycle();
    chk("post_reset_silent", 64'(n_out - n_before), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
